// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

  localparam int unsigned TO_W = 8;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating busy-wait counter; hit_o flags that the count has reached TIMEOUT.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access, data first.
// Optional MEM_ARB_STATS_EN adds grant and stall statistics counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic              err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_i_cnt,
  output logic [31:0]       stat_d_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  arb_state_t        state_q, state_d;
  grant_t            gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_served_q, i_served_d;
  logic              d_served_q, d_served_d;
  logic              to_q, to_d;
  logic              d_req;
  logic              ctr_clr, ctr_inc, ctr_hit;

  assign d_req = d_ren | d_wen;

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr_i(ctr_clr),
    .inc_i(ctr_inc),
    .hit_o(ctr_hit)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    to_d      = to_q;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
    // A served flag only survives while its request stays high.
    i_served_d = i_served_q & i_req;
    d_served_d = d_served_q & d_req;

    unique case (state_q)
      IDLE: begin
        if (d_req && !d_served_q) begin
          gnt_d   = GNT_D;
          wr_d    = d_wen;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          to_d    = 1'b0;
          state_d = ISSUE;
        end else if (i_req && !i_served_q) begin
          gnt_d   = GNT_I;
          wr_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
          to_d    = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!ram_busy) begin
          if (gnt_q == GNT_I) begin
            i_rdata_d = ram_rdata;
          end else if (!wr_q) begin
            d_rdata_d = ram_rdata;
          end
          ctr_clr = 1'b1;
          state_d = DONE;
        end else begin
          ctr_inc = 1'b1;
          if (ctr_hit) begin
            to_d    = 1'b1;
            ctr_clr = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (gnt_q == GNT_I) begin
          i_served_d = i_req;
        end else begin
          d_served_d = d_req;
        end
        to_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_I;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_served_q <= 1'b0;
      d_served_q <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_served_q <= i_served_d;
      d_served_q <= d_served_d;
      to_q       <= to_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wen   = (state_q == ISSUE) &&  wr_q;
  assign ram_ren   = (state_q == ISSUE) && !wr_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = (state_q == DONE) && (gnt_q == GNT_I);
  assign d_ready   = (state_q == DONE) && (gnt_q == GNT_D);
  assign err       = (state_q == DONE) && to_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_q, stat_d_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_q     <= '0;
      stat_d_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      if (i_ready) stat_i_q <= stat_i_q + 32'd1;
      if (d_ready) stat_d_q <= stat_d_q + 32'd1;
      if ((state_q == WAIT) && ram_busy) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_i_cnt     = stat_i_q;
  assign stat_d_cnt     = stat_d_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter against a small RAM model with programmable busy.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_ren, d_wen;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_wen, ram_ren, ram_busy;
  logic        err;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_cnt, stat_d_cnt, stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ready  (i_ready),
    .d_ren    (d_ren),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wen  (ram_wen),
    .ram_ren  (ram_ren),
    .ram_rdata(ram_rdata),
    .ram_busy (ram_busy),
    .err      (err)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_i_cnt    (stat_i_cnt),
    .stat_d_cnt    (stat_d_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // RAM model: unwritten words return a fixed function of the address.
  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return (a ^ 32'hA5A5_0000) + 32'h0000_1111;
  endfunction

  logic [31:0] mem   [64];
  logic        mem_v [64];
  int          busy_len   = 0;
  bit          busy_stuck = 1'b0;
  int          busy_ctr;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int k = 0; k < 64; k++) mem_v[k] <= 1'b0;
      busy_ctr  <= 0;
      ram_rdata <= '0;
    end else begin
      if (ram_wen) begin
        mem[ram_addr[7:2]]   <= ram_wdata;
        mem_v[ram_addr[7:2]] <= 1'b1;
      end
      if (ram_ren) ram_rdata <= mem_v[ram_addr[7:2]] ? mem[ram_addr[7:2]] : ram_fn(ram_addr);
      if (ram_ren || ram_wen) busy_ctr <= busy_len;
      else if (busy_ctr != 0) busy_ctr <= busy_ctr - 1;
    end
  end

  assign ram_busy = busy_stuck | (busy_ctr != 0);

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          to;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_issue = 0;
  int   n_ready = 0;
  int   issue_cyc = 0;
  int   ready_cyc = 0;

  task automatic expect_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input bit to, input int lat);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.to = to; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Advance n cycles, scoring every RAM access and ready pulse against the queue.
  task automatic run_cycles(input int n, input bit drop);
    exp_t        e;
    logic [31:0] got_rd;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ram_ren || ram_wen) begin
        n_tests++; n_issue++; issue_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_issue: unexpected access ren=%b wen=%b addr=%h", ram_ren, ram_wen,
                   ram_addr);
        end else begin
          e = exp_q[0];
          if (ram_wen !== e.wr || ram_ren !== !e.wr || ram_addr !== e.addr ||
              (e.wr && ram_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL sb_issue: got wen=%b ren=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                     ram_wen, ram_ren, ram_addr, ram_wdata, e.wr, e.addr, e.wdata);
          end
        end
      end
      if (i_ready || d_ready) begin
        n_tests++; n_ready++; ready_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_ready: unexpected ready i=%b d=%b", i_ready, d_ready);
        end else begin
          e = exp_q.pop_front();
          got_rd = e.is_d ? d_rdata : i_rdata;
          if (d_ready !== e.is_d || i_ready !== !e.is_d || err !== e.to ||
              got_rd !== e.rdata || (cyc - issue_cyc) != e.lat) begin
            n_fail++;
            $display("FAIL sb_ready: got i=%b d=%b err=%b rdata=%h lat=%0d, want d=%b err=%b rdata=%h lat=%0d",
                     i_ready, d_ready, err, got_rd, cyc - issue_cyc, e.is_d, e.to, e.rdata, e.lat);
          end
        end
        if (drop) begin
          if (i_ready) i_req = 1'b0;
          if (d_ready) begin d_ren = 1'b0; d_wen = 1'b0; end
        end
      end else if (err) begin
        n_tests++; n_fail++;
        $display("FAIL sb_err: err=1 without ready, want err=0");
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({i_rdata, d_rdata, ram_addr, ram_wdata, i_ready, d_ready, ram_wen, ram_ren, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: i_rdata=%h d_rdata=%h ram_addr=%h rdy=%b%b wen=%b ren=%b err=%b, want all 0",
               i_rdata, d_rdata, ram_addr, i_ready, d_ready, ram_wen, ram_ren, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int c0;
    c0 = cyc; i_addr = 32'h10; i_req = 1'b1;
    expect_txn(1'b0, 1'b0, 32'h10, '0, 32'h0050_0093, 1'b0, 2);
    run_cycles(8, 1'b1);
    n_tests++;
    if (issue_cyc != c0 + 1 || ready_cyc != c0 + 3) begin
      n_fail++;
      $display("FAIL fetch_latency: ren at +%0d ready at +%0d, want +1 and +3",
               issue_cyc - c0, ready_cyc - c0);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL fetch_pending: %0d outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int r0;
    r0 = n_ready;
    i_addr = 32'h40; i_req = 1'b1; d_addr = 32'h20; d_ren = 1'b1;
    expect_txn(1'b1, 1'b0, 32'h20, '0, ram_fn(32'h20), 1'b0, 2);
    expect_txn(1'b0, 1'b0, 32'h40, '0, ram_fn(32'h40), 1'b0, 2);
    run_cycles(14, 1'b1);
    n_tests++;
    if (exp_q.size() != 0 || n_ready - r0 != 2) begin
      n_fail++;
      $display("FAIL simul_count: readies=%0d outstanding=%0d, want 2 and 0", n_ready - r0,
               exp_q.size());
    end
  endtask

  task automatic test_store_busy();
    int i0;
    i0 = n_issue;
    busy_len = 3; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF; d_wen = 1'b1;
    expect_txn(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, ram_fn(32'h20), 1'b0, 5);
    run_cycles(12, 1'b1);
    busy_len = 0; d_ren = 1'b1; d_wdata = 32'h1234_5678;
    expect_txn(1'b1, 1'b0, 32'h8, '0, 32'hDEAD_BEEF, 1'b0, 2);
    run_cycles(8, 1'b1);
    n_tests++;
    if (exp_q.size() != 0 || n_issue - i0 != 2) begin
      n_fail++;
      $display("FAIL store_count: accesses=%0d outstanding=%0d, want 2 and 0", n_issue - i0,
               exp_q.size());
    end
  endtask

  task automatic test_held_request();
    int i0;
    i0 = n_issue;
    d_addr = 32'h30; d_ren = 1'b1;
    expect_txn(1'b1, 1'b0, 32'h30, '0, ram_fn(32'h30), 1'b0, 2);
    run_cycles(14, 1'b0);
    n_tests++;
    if (n_issue - i0 != 1) begin
      n_fail++; $display("FAIL held_once: accesses=%0d, want 1", n_issue - i0);
    end
    d_ren = 1'b0;
    run_cycles(1, 1'b0);
    d_ren = 1'b1;
    expect_txn(1'b1, 1'b0, 32'h30, '0, ram_fn(32'h30), 1'b0, 2);
    run_cycles(8, 1'b1);
    n_tests++;
    if (n_issue - i0 != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_rearm: accesses=%0d outstanding=%0d, want 2 and 0", n_issue - i0,
               exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int c0;
    // Four busy cycles is the most tolerated; busy clears in time.
    busy_len = 4; d_addr = 32'h44; d_ren = 1'b1;
    expect_txn(1'b1, 1'b0, 32'h44, '0, ram_fn(32'h44), 1'b0, 6);
    run_cycles(12, 1'b1);
    busy_len = 0; busy_stuck = 1'b1; d_addr = 32'h48; d_ren = 1'b1;
    expect_txn(1'b1, 1'b0, 32'h48, '0, ram_fn(32'h44), 1'b1, 6);
    run_cycles(12, 1'b1);
    busy_stuck = 1'b0;
    c0 = cyc; i_addr = 32'h14; i_req = 1'b1;
    expect_txn(1'b0, 1'b0, 32'h14, '0, ram_fn(32'h14), 1'b0, 2);
    run_cycles(8, 1'b1);
    n_tests++;
    if (issue_cyc != c0 + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_idle: next ren at +%0d outstanding=%0d, want +1 and 0",
               issue_cyc - c0, exp_q.size());
    end
  endtask

  task automatic test_reset_in_wait();
    int r0, i0;
    busy_stuck = 1'b1; d_addr = 32'h50; d_ren = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; d_ren = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({i_rdata, d_rdata, ram_addr, ram_wdata, i_ready, d_ready, ram_wen, ram_ren, err} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: i_rdata=%h d_rdata=%h ram_addr=%h rdy=%b%b wen=%b ren=%b err=%b, want all 0",
               i_rdata, d_rdata, ram_addr, i_ready, d_ready, ram_wen, ram_ren, err);
    end
    rst = 1'b0; busy_stuck = 1'b0;
    r0 = n_ready; i0 = n_issue;
    run_cycles(10, 1'b1);
    n_tests++;
    if (n_ready != r0 || n_issue != i0) begin
      n_fail++;
      $display("FAIL rst_wait_ack: readies=%0d accesses=%0d after reset, want 0 and 0",
               n_ready - r0, n_issue - i0);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store_busy();
    test_held_request();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester (PC side) and the data-access requester (load/store side).
- Grants one requester at a time, drives the RAM address, data and write-enable, and waits out the RAM busy handshake.
- Returns the read data with a one-cycle ready pulse, so the PC advances only after fetch, and writeback only after load.
- Sits between the control/PC/ALU datapath and the RAM model.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM port.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles ram_busy may stay high before abort; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request, held until i_ready.
- i_addr  in  ADDR_W  fetch address (PC).
- i_rdata  out  DATA_W  fetched instruction, registered.
- i_ready  out  1  one-cycle pulse: i_rdata valid.
- d_ren  in  1  data load request, held until d_ready.
- d_wen  in  1  data store request, held until d_ready; d_ren&d_wen treated as store.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data (rs2).
- d_rdata  out  DATA_W  load data, registered.
- d_ready  out  1  one-cycle pulse: load data valid / store done.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wen  out  1  RAM write enable.
- ram_ren  out  1  RAM read enable.
- ram_rdata  in  DATA_W  RAM read data.
- ram_busy  in  1  RAM operation in progress.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values:
  - All outputs 0: i_rdata, d_rdata, ram_addr and ram_wdata all zero; ready, enable and err bits low.
  - State IDLE, timeout counter 0, last-served flags cleared.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Data has fixed priority. If (d_ren|d_wen) and not d_served, grant D.
  - Else if i_req and not i_served, grant I.
  - Else stay in IDLE.
  - On grant, latch the address, wdata and write flag into internal registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ram_addr and ram_wdata come from the latched registers.
  - ram_wen=latched write flag; ram_ren=!write flag.
  - Go to WAIT.
- WAIT:
  - ram_addr and ram_wdata are held; ram_wen/ram_ren are low.
  - The counter increments each cycle ram_busy=1.
  - When ram_busy=0, capture ram_rdata into i_rdata or d_rdata (stores leave d_rdata unchanged), then go to DONE.
  - When the counter reaches TIMEOUT, pulse err for 1 cycle, go to DONE without updating rdata, and still pulse ready.
- DONE (1 cycle):
  - Pulse the granted requester's ready and set its served flag, then return to IDLE.
- Served flags:
  - A served flag clears when its request input is seen low.
  - A request held high through the ready cycle is never re-granted.
  - Requester must drop and re-raise its request for a new transaction.
  - A new PC is presented as i_req low for ≥1 cycle.
- Minimum latency, request to ready: 4 cycles (IDLE→ISSUE→WAIT→DONE), assuming busy is low on the first WAIT cycle.
- Simultaneous I and D in IDLE: D wins; I is served afterwards.
- A request dropped mid-transaction does not cancel it; the transaction completes and ready pulses anyway.
- rst in any state:
  - Next cycle in IDLE with all outputs at reset values.
  - No ram_wen is issued after the rst edge.
- Counter and address arithmetic: no wrap. The counter saturates at TIMEOUT and is cleared on leaving WAIT.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds outputs stat_i_cnt[31:0], stat_d_cnt[31:0], stat_stall_cnt[31:0].
  - stat_i_cnt / stat_d_cnt count completed grants (DONE cycles) per requester.
  - stat_stall_cnt counts WAIT cycles with ram_busy=1.
  - All three clear on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, DONE};
  - grant enum grant_t {GNT_I, GNT_D};
  - localparam TO_W=8.
- One sub-module, arb_timeout_ctr: saturating counter with clr/inc inputs and a hit output.

Test Plan:
- Fetch only: i_req=1, i_addr=0x10, ram_busy low, ram_rdata=0x00500093 → ram_ren pulse in cycle 2, i_rdata=0x00500093, i_ready pulse in cycle 4.
- Simultaneous requests: i_req=1 and d_ren=1 (d_addr=0x20) in the same cycle → first ram_addr=0x20 with d_ready; then ram_addr=i_addr with i_ready; no overlap.
- Store with busy: d_wen=1, d_addr=0x8, d_wdata=0xDEADBEEF, ram_busy high 3 cycles → one ram_wen pulse with those values, d_ready 3 cycles later than the no-busy case.
- Held request: d_ren held high 10 cycles after d_ready → exactly one RAM transaction; drop then raise → second transaction.
- Timeout: TIMEOUT=4, ram_busy stuck high → err and d_ready pulse in the same cycle, d_rdata unchanged, FSM back in IDLE.
- Reset mid-WAIT: assert rst during WAIT → next cycle all outputs 0, and the pending request is not acknowledged.
